// File: rtl/hilo_pkg.sv
// Shared constants, opcodes, FSM states and the operand magnitude helper
// for the HI/LO multiply unit.
package hilo_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    SIGN = 2'b10
  } state_e;

  // Two's complement magnitude; the most negative value maps onto itself,
  // which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic [WIDTH-1:0] r;
    if (is_signed && v[WIDTH-1]) begin
      r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/hilo_mult_ctrl_if.sv
// Request/response bundle between the control unit and the HI/LO multiply unit.
interface hilo_mult_ctrl_if
  import hilo_pkg::*;
  ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/mult_step.sv
// One combinational shift-add iteration of the unsigned magnitude multiply.
module mult_step
  import hilo_pkg::*;
(
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplr,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplr_next
);

  assign acc_next   = mplr[0] ? (acc + mcand) : acc;
  assign mcand_next = mcand << 1'b1;
  assign mplr_next  = mplr >> 1'b1;

endmodule

// File: rtl/hilo_mult_ctrl.sv
// Sequential MULT/MULTU engine with MTHI/MTLO writes and the HI/LO registers.
// Optional build macro HILO_EARLY_TERM_EN ends RUN once the multiplier is exhausted.
module hilo_mult_ctrl
  import hilo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  hilo_mult_ctrl_if.slave  bus
);

  state_e              state_r;
  logic                busy_r;
  logic                done_r;
  logic [WIDTH-1:0]    hi_r;
  logic [WIDTH-1:0]    lo_r;
  logic [2*WIDTH-1:0]  acc_r;
  logic [2*WIDTH-1:0]  mcand_r;
  logic [WIDTH-1:0]    mplr_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                neg_r;

  logic [2*WIDTH-1:0]  acc_next_s;
  logic [2*WIDTH-1:0]  mcand_next_s;
  logic [WIDTH-1:0]    mplr_next_s;
  logic                is_signed_s;
  logic                run_last_s;
  logic [2*WIDTH-1:0]  result_s;

  mult_step u_step (
    .acc        (acc_r),
    .mcand      (mcand_r),
    .mplr       (mplr_r),
    .acc_next   (acc_next_s),
    .mcand_next (mcand_next_s),
    .mplr_next  (mplr_next_s)
  );

  assign is_signed_s = (bus.op == OP_MULT);
  assign result_s    = neg_r ? (~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_r;

`ifdef HILO_EARLY_TERM_EN
  assign run_last_s = (mplr_next_s == {WIDTH{1'b0}});
`else
  assign run_last_s = (cnt_r == CNT_LAST);
`endif

  // Control FSM, datapath registers and the architectural HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      mcand_r <= {(2*WIDTH){1'b0}};
      mplr_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      neg_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                acc_r   <= {(2*WIDTH){1'b0}};
                mcand_r <= {{WIDTH{1'b0}}, magnitude(bus.a, is_signed_s)};
                mplr_r  <= magnitude(bus.b, is_signed_s);
                neg_r   <= is_signed_s & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                cnt_r   <= {CNT_W{1'b0}};
                busy_r  <= 1'b1;
                state_r <= RUN;
              end
              OP_MTHI: begin
                hi_r   <= bus.a;
                done_r <= 1'b1;
              end
              OP_MTLO: begin
                lo_r   <= bus.a;
                done_r <= 1'b1;
              end
              default: begin
                state_r <= IDLE;
              end
            endcase
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          acc_r   <= acc_next_s;
          mcand_r <= mcand_next_s;
          mplr_r  <= mplr_next_s;
          cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (run_last_s) begin
            state_r <= SIGN;
          end else begin
            state_r <= RUN;
          end
        end
        SIGN: begin
          hi_r    <= result_s[2*WIDTH-1:WIDTH];
          lo_r    <= result_s[WIDTH-1:0];
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Directed plus random checks of hilo_mult_ctrl against an arithmetic reference model.
module tb_hilo_mult_ctrl;
  import hilo_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  hilo_mult_ctrl_if bus ();

  hilo_mult_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision product plus the expected DONE latency in edges.
  task automatic run_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
    logic [63:0] prod;
    logic [31:0] mb;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int n;
    int cyc;
    bit got;
    bit busy_ok;
    bit hold_ok;
    if (op == OP_MULT) begin
      prod = 64'(longint'($signed(a)) * longint'($signed(b)));
      mb   = b[31] ? 32'(-b) : b;
    end else begin
      prod = {32'd0, a} * {32'd0, b};
      mb   = b;
    end
`ifdef HILO_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < 32; i++) if (mb[i]) n = i + 1;
`else
    n = 32;
`endif
    old_hi = model_hi;
    old_lo = model_lo;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom_range(0, 3));
    cyc = 0; got = 1'b0; busy_ok = 1'b1; hold_ok = 1'b1;
    if (bus.busy !== 1'b1) busy_ok = 1'b0;
    while (!got && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        if (bus.hi !== old_hi || bus.lo !== old_lo) hold_ok = 1'b0;
      end
    end
    model_hi = prod[63:32];
    model_lo = prod[31:0];
    chk({tag, " latency"}, 64'(cyc), 64'(n + 1));
    chk({tag, " hi"}, 64'(bus.hi), 64'(model_hi));
    chk({tag, " lo"}, 64'(bus.lo), 64'(model_lo));
    chk({tag, " busy_during_run"}, 64'(busy_ok), 64'd1);
    chk({tag, " hilo_hold"}, 64'(hold_ok), 64'd1);
    chk({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic run_mt(input logic [1:0] op, input logic [31:0] a, input string tag);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = $urandom;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (op == OP_MTHI) model_hi = a; else model_lo = a;
    chk({tag, " done"}, 64'(bus.done), 64'd1);
    chk({tag, " busy"}, 64'(bus.busy), 64'd0);
    chk({tag, " hi"}, 64'(bus.hi), 64'(model_hi));
    chk({tag, " lo"}, 64'(bus.lo), 64'(model_lo));
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int dones;
    int busies;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    n_cmp = 0; n_err = 0;
    model_hi = 32'd0; model_lo = 32'd0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = 32'd0; bus.b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_mul(OP_MULT, 32'd5, 32'd3, "mult_5x3");
    chk("plan 5x3 lo", 64'(bus.lo), 64'h0000_000F);
    run_mul(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult_m1xm2");
    chk("plan m1xm2 lo", 64'(bus.lo), 64'd2);
    run_mul(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "multu_big");
    chk("plan multu hi", 64'(bus.hi), 64'hFFFF_FFFD);
    run_mul(OP_MULT, 32'hFFFF_FFF4, 32'd2, "mult_m12x2");
    chk("plan m12x2 lo", 64'(bus.lo), 64'hFFFF_FFE8);
    run_mul(OP_MULT, 32'hFFFF_FFF6, 32'hFFFF_FFFB, "mult_m10xm5");
    run_mul(OP_MULT, 32'h8000_0000, 32'h8000_0000, "mult_minxmin");
    chk("plan minxmin hi", 64'(bus.hi), 64'h4000_0000);
    run_mul(OP_MULTU, 32'h1234_5678, 32'd0, "multu_zero");

    // START during RUN must be ignored, not queued.
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd7; bus.b = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.op = OP_MTLO; bus.a = 32'h1234;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = (bus.done === 1'b1) ? 1 : 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    model_hi = 32'd0; model_lo = 32'd63;
    chk("ignored_start dones", 64'(dones), 64'd1);
    chk("ignored_start lo", 64'(bus.lo), 64'd63);
    chk("ignored_start hi", 64'(bus.hi), 64'd0);

    // Asynchronous reset in the middle of a multiply.
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'hABCD_0123; bus.b = 32'h8765_4321;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    model_hi = 32'd0; model_lo = 32'd0;
    chk("midreset hi", 64'(bus.hi), 64'd0);
    chk("midreset lo", 64'(bus.lo), 64'd0);
    chk("midreset busy", 64'(bus.busy), 64'd0);
    chk("midreset done", 64'(bus.done), 64'd0);
    @(negedge clk); rst = 1'b0;
    dones = 0; busies = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
      if (bus.busy === 1'b1) busies++;
    end
    chk("midreset no_done", 64'(dones), 64'd0);
    chk("midreset no_busy", 64'(busies), 64'd0);

    run_mt(OP_MTHI, 32'hDEAD_BEEF, "mthi");
    chk("plan mthi lo", 64'(bus.lo), 64'd0);

    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 300));
      if (op == OP_MULT || op == OP_MULTU) run_mul(op, a, b, "rand_mul");
      else run_mt(op, a, "rand_mt");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_mult_ctrl.md
# hilo_mult_ctrl

Sequential HI/LO multiply unit for the processor datapath. It accepts MULT (signed) and MULTU (unsigned) requests on 32-bit operands and forms the 64-bit product by iterative shift-add over multiple cycles. It also services MTHI/MTLO writes and holds the architectural HI and LO registers. A start/busy/done handshake lets the control unit stall on a multiply in progress.

## Interface
- WIDTH, 32, operand width; HI and LO are WIDTH bits each, the product is 2*WIDTH.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request strobe; sampled only in IDLE.
- OP  in  2  00 MULT (signed), 01 MULTU, 10 MTHI, 11 MTLO.
- A  in  WIDTH  multiplicand, or the write data for MTHI/MTLO.
- B  in  WIDTH  multiplier.
- BUSY  out  1  high while in RUN or SIGN.
- DONE  out  1  one-cycle pulse when HI/LO have just been updated.
- HI  out  WIDTH  architectural HI register.
- LO  out  WIDTH  architectural LO register.

## Operation
- States:
  - IDLE: START with OP=MULT or MULTU goes to RUN.
  - RUN: goes to SIGN when the step count reaches WIDTH, or on early exit.
  - SIGN: always returns to IDLE.
- Capture (IDLE, START, MULT or MULTU):
  - Latch the magnitudes |A| and |B|. For MULTU, use the raw values.
  - Latch neg = A[31]^B[31] for MULT; neg = 0 for MULTU.
  - Clear the 64-bit accumulator and the step counter.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned; no overflow.
- RUN step, one per cycle:
  - If the multiplier LSB is 1, acc += mcand.
  - mcand <<= 1 (64-bit register).
  - mplr >>= 1.
  - cnt++.
- SIGN:
  - {HI,LO} <= neg ? -acc : acc, using a 64-bit two's complement.
  - DONE=1 for the next cycle.
- MTHI/MTLO in IDLE with START:
  - HI (or LO) <= A at the same edge.
  - DONE pulses the following cycle. BUSY stays 0 and the other register is unchanged.
- START while BUSY is ignored. Operands are not re-sampled and the request is not queued.
- A, B and OP are don't-care except at the START edge in IDLE.
- Reset at any time forces:
  - state=IDLE
  - HI=0, LO=0, BUSY=0, DONE=0
  - all internal registers 0
  
  An in-flight multiply is discarded and no DONE is produced.

## Timing
- Reset values: HI=0, LO=0, BUSY=0, DONE=0.
- MULT/MULTU, with START sampled at edge k:
  - BUSY=1 from edge k+1 through edge k+n+1.
  - n RUN cycles, then 1 SIGN cycle.
  - HI/LO update at edge k+n+1; DONE=1 and BUSY=0 in the cycle after that edge.
  - Without early termination, n=32, so latency is 33 cycles.
- MTHI/MTLO: register updates at edge k; DONE=1 in cycle k+1.
- A new START is accepted in the same cycle DONE is high, since state is IDLE. Back-to-back throughput is therefore 1 request per n+2 cycles.
- HI/LO hold their old values throughout RUN. Only SIGN writes them.

## Configuration
- HILO_EARLY_TERM_EN
  - Defined: RUN exits to SIGN at the edge where the shifted mplr becomes 0. If |B|==0 at capture, RUN lasts one cycle. This gives n = max(1, index of highest set bit of |B| + 1).
  - Undefined: n is always 32 and latency is fixed.
- The result is identical either way.

## Structure
- Package hilo_pkg holds:
  - WIDTH default.
  - OP encodings: OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO.
  - State enum: IDLE, RUN, SIGN.
- Sub-module mult_step holds the combinational single iteration: inputs acc/mcand/mplr, outputs next acc/mcand/mplr.
- hilo_mult_ctrl holds the FSM, counter, capture and sign logic, and the HI/LO registers.

## Test plan
- MULT A=5, B=3: HI=0x00000000, LO=0x0000000F. DONE exactly 33 cycles after START (3 with HILO_EARLY_TERM_EN).
- MULT A=0xFFFFFFFF, B=0xFFFFFFFE: HI=0, LO=2.
- MULTU on the same operands: HI=0xFFFFFFFD, LO=0x00000002.
- MULT A=0xFFFFFFF4, B=2: HI=0xFFFFFFFF, LO=0xFFFFFFE8.
- MULT A=0xFFFFFFF6, B=0xFFFFFFFB: LO=0x32.
- MULT A=0x80000000, B=0x80000000: HI=0x40000000, LO=0.
- START MULT 7×9, then pulse START (MTLO, A=0x1234) at cycle 5: the second request is ignored; final LO=63, HI=0, single DONE.
- Assert RST at cycle 10 of a multiply: HI=LO=0 and BUSY=0 immediately; no DONE.
- Then issue MTHI A=0xDEADBEEF: HI=0xDEADBEEF, LO=0, DONE pulses once.
